// File: rtl/disp_frame_commit.sv
// Tear-free hand-off of game display state into the pixel-clock domain.
// A toggle request is copied into shadow registers one obstacle slot per cycle, starting only on a vblank rising edge.
module disp_frame_commit #(
  parameter int unsigned N_OBS        = 10,
  parameter int unsigned RST_X        = 700,
  parameter int unsigned RST_Y        = 500,
  parameter int unsigned RST_PLAYER_Y = 240
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vblank,
  input  logic                  upd_req_tgl,
  output logic                  upd_ack_tgl,
  input  logic [N_OBS*10-1:0]   obs_x_left_in,
  input  logic [N_OBS*10-1:0]   obs_x_right_in,
  input  logic [N_OBS*9-1:0]    obs_y_up_in,
  input  logic [N_OBS*9-1:0]    obs_y_down_in,
  input  logic [8:0]            player_y_in,
  input  logic [1:0]            gamemode_in,
  output logic [N_OBS*10-1:0]   obs_x_left,
  output logic [N_OBS*10-1:0]   obs_x_right,
  output logic [N_OBS*9-1:0]    obs_y_up,
  output logic [N_OBS*9-1:0]    obs_y_down,
  output logic [8:0]            player_y,
  output logic [1:0]            gamemode,
  output logic                  commit_pulse,
  output logic                  busy,
  output logic [7:0]            overrun_cnt
);

  localparam int unsigned XW    = 10;
  localparam int unsigned YW    = 9;
  localparam int unsigned PW    = 9;
  localparam int unsigned GW    = 2;
  localparam int unsigned CW    = 8;
  localparam int unsigned IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;

  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_OBS - 1);
  localparam logic [N_OBS*XW-1:0] X_RST    = {N_OBS{XW'(RST_X)}};
  localparam logic [N_OBS*YW-1:0] Y_RST    = {N_OBS{YW'(RST_Y)}};
  localparam logic [PW-1:0]       P_RST    = PW'(RST_PLAYER_Y);
  localparam logic [CW-1:0]       CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    COPY    = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  req_meta_q, req_s_q, req_d_q, vblank_d_q;
  logic                  req_lat_q, req_lat_d;
  logic                  ack_q, ack_d;
  logic                  commit_q, commit_d;
  logic                  busy_q, busy_d;
  logic [CW-1:0]         ovr_q, ovr_d;
  logic [N_OBS*XW-1:0]   xl_q, xl_d, xr_q, xr_d;
  logic [N_OBS*YW-1:0]   yu_q, yu_d, yd_q, yd_d;
  logic [PW-1:0]         py_q, py_d;
  logic [GW-1:0]         gm_q, gm_d;
  logic                  vb_rise;

  assign vb_rise = vblank & ~vblank_d_q;

  // Next-state, copy datapath and bookkeeping
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    req_lat_d = req_lat_q;
    ack_d     = ack_q;
    commit_d  = 1'b0;
    ovr_d     = ovr_q;
    xl_d      = xl_q;
    xr_d      = xr_q;
    yu_d      = yu_q;
    yd_d      = yd_q;
    py_d      = py_q;
    gm_d      = gm_q;

    case (state_q)
      IDLE: begin
        if (req_s_q != ack_q) begin
          state_d   = WAIT_VB;
          req_lat_d = req_s_q;
        end
      end
      WAIT_VB: begin
        if (vb_rise) begin
          state_d = COPY;
          idx_d   = '0;
        end
      end
      COPY: begin
        xl_d[int'(idx_q)*XW +: XW] = obs_x_left_in[int'(idx_q)*XW +: XW];
        xr_d[int'(idx_q)*XW +: XW] = obs_x_right_in[int'(idx_q)*XW +: XW];
        yu_d[int'(idx_q)*YW +: YW] = obs_y_up_in[int'(idx_q)*YW +: YW];
        yd_d[int'(idx_q)*YW +: YW] = obs_y_down_in[int'(idx_q)*YW +: YW];
        if (idx_q == '0) begin
          py_d = player_y_in;
          gm_d = gamemode_in;
        end
        if (idx_q == IDX_LAST) begin
          state_d  = DONE;
          commit_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        ack_d   = req_lat_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A re-toggle during DONE is served by IDLE next cycle, so it is not an overrun
    if (((state_q == WAIT_VB) || (state_q == COPY)) && (req_s_q != req_d_q) &&
        (ovr_q != CNT_MAX)) begin
      ovr_d = ovr_q + CW'(1);
    end

    busy_d = (state_d == WAIT_VB) || (state_d == COPY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      req_d_q    <= 1'b0;
      vblank_d_q <= 1'b0;
      req_lat_q  <= 1'b0;
      ack_q      <= 1'b0;
      commit_q   <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= '0;
      xl_q       <= X_RST;
      xr_q       <= X_RST;
      yu_q       <= Y_RST;
      yd_q       <= Y_RST;
      py_q       <= P_RST;
      gm_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      req_meta_q <= upd_req_tgl;
      req_s_q    <= req_meta_q;
      req_d_q    <= req_s_q;
      vblank_d_q <= vblank;
      req_lat_q  <= req_lat_d;
      ack_q      <= ack_d;
      commit_q   <= commit_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      xl_q       <= xl_d;
      xr_q       <= xr_d;
      yu_q       <= yu_d;
      yd_q       <= yd_d;
      py_q       <= py_d;
      gm_q       <= gm_d;
    end
  end

  assign upd_ack_tgl  = ack_q;
  assign commit_pulse = commit_q;
  assign busy         = busy_q;
  assign overrun_cnt  = ovr_q;
  assign obs_x_left   = xl_q;
  assign obs_x_right  = xr_q;
  assign obs_y_up     = yu_q;
  assign obs_y_down   = yd_q;
  assign player_y     = py_q;
  assign gamemode     = gm_q;

endmodule

// File: tb/tb_disp_frame_commit.sv
// Scoreboard bench for disp_frame_commit: each accepted request queues the input snapshot it must commit.
module tb_disp_frame_commit;

  localparam int unsigned N = 10;

  typedef struct {
    logic [N*10-1:0] xl;
    logic [N*10-1:0] xr;
    logic [N*9-1:0]  yu;
    logic [N*9-1:0]  yd;
    logic [8:0]      py;
    logic [1:0]      gm;
    logic            ack;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            vblank;
  logic            req;
  logic            upd_ack_tgl;
  logic [N*10-1:0] in_xl, in_xr, out_xl, out_xr;
  logic [N*9-1:0]  in_yu, in_yd, out_yu, out_yd;
  logic [8:0]      in_py, out_py;
  logic [1:0]      in_gm, out_gm;
  logic            commit_pulse, busy;
  logic [7:0]      overrun_cnt;

  // Model of what the screen should currently show
  logic [N*10-1:0] m_xl, m_xr;
  logic [N*9-1:0]  m_yu, m_yd;
  logic [8:0]      m_py;
  logic [1:0]      m_gm;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ca;

  disp_frame_commit #(.N_OBS(N), .RST_X(700), .RST_Y(500), .RST_PLAYER_Y(240)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vblank         (vblank),
    .upd_req_tgl    (req),
    .upd_ack_tgl    (upd_ack_tgl),
    .obs_x_left_in  (in_xl),
    .obs_x_right_in (in_xr),
    .obs_y_up_in    (in_yu),
    .obs_y_down_in  (in_yd),
    .player_y_in    (in_py),
    .gamemode_in    (in_gm),
    .obs_x_left     (out_xl),
    .obs_x_right    (out_xr),
    .obs_y_up       (out_yu),
    .obs_y_down     (out_yd),
    .player_y       (out_py),
    .gamemode       (out_gm),
    .commit_pulse   (commit_pulse),
    .busy           (busy),
    .overrun_cnt    (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_xl = {N{10'd700}};
    m_xr = {N{10'd700}};
    m_yu = {N{9'd500}};
    m_yd = {N{9'd500}};
    m_py = 9'd240;
    m_gm = 2'd0;
  endtask

  task automatic chk_shadows(input string tag);
    chk({tag, "_xl"}, 128'(out_xl), 128'(m_xl));
    chk({tag, "_xr"}, 128'(out_xr), 128'(m_xr));
    chk({tag, "_yu"}, 128'(out_yu), 128'(m_yu));
    chk({tag, "_yd"}, 128'(out_yd), 128'(m_yd));
    chk({tag, "_py"}, 128'(out_py), 128'(m_py));
    chk({tag, "_gm"}, 128'(out_gm), 128'(m_gm));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_xl"},   128'(out_xl), 128'({N{10'd700}}));
    chk({tag, "_xr"},   128'(out_xr), 128'({N{10'd700}}));
    chk({tag, "_yu"},   128'(out_yu), 128'({N{9'd500}}));
    chk({tag, "_yd"},   128'(out_yd), 128'({N{9'd500}}));
    chk({tag, "_py"},   128'(out_py), 128'(9'd240));
    chk({tag, "_gm"},   128'(out_gm), 128'(2'd0));
    chk({tag, "_ack"},  128'(upd_ack_tgl), 128'(1'b0));
    chk({tag, "_busy"}, 128'(busy), 128'(1'b0));
    chk({tag, "_cp"},   128'(commit_pulse), 128'(1'b0));
    chk({tag, "_ovr"},  128'(overrun_cnt), 128'(8'd0));
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < int'(N); i++) begin
      in_xl[i*10 +: 10] = 10'($urandom_range(0, 1023));
      in_xr[i*10 +: 10] = 10'($urandom_range(0, 1023));
      in_yu[i*9 +: 9]   = 9'($urandom_range(0, 511));
      in_yd[i*9 +: 9]   = 9'($urandom_range(0, 511));
    end
    in_py = 9'($urandom_range(0, 511));
    in_gm = 2'($urandom_range(0, 3));
  endtask

  // Expected commit = the inputs held stable since the request, acked with the current request level
  task automatic push_exp();
    exp_t e;
    e.xl = in_xl; e.xr = in_xr; e.yu = in_yu; e.yd = in_yd;
    e.py = in_py; e.gm = in_gm; e.ack = req;
    exp_q.push_back(e);
  endtask

  // One blanking interval; returns the cycle (1-based from the rise) of commit_pulse, 0 if none
  task automatic do_frame(input int vb_len, input int tgl_at, output int commit_at);
    commit_at = 0;
    vblank = 1'b1;
    for (int i = 1; i <= vb_len; i++) begin
      @(posedge clk);
      #1;
      if (commit_pulse && commit_at == 0) commit_at = i;
      if (i == tgl_at) req = ~req;
    end
    vblank = 1'b0;
    cyc(3);
  endtask

  // Monitor: every commit_pulse must match the oldest expected snapshot
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && commit_pulse) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", 128'(commit_pulse), 128'(1'b0));
        end else begin
          e = exp_q.pop_front();
          chk("mon_xl", 128'(out_xl), 128'(e.xl));
          chk("mon_xr", 128'(out_xr), 128'(e.xr));
          chk("mon_yu", 128'(out_yu), 128'(e.yu));
          chk("mon_yd", 128'(out_yd), 128'(e.yd));
          chk("mon_py", 128'(out_py), 128'(e.py));
          chk("mon_gm", 128'(out_gm), 128'(e.gm));
          m_xl = e.xl; m_xr = e.xr; m_yu = e.yu; m_yd = e.yd; m_py = e.py; m_gm = e.gm;
          @(negedge clk);
          chk("mon_ack", 128'(upd_ack_tgl), 128'(e.ack));
          chk("mon_pulse_width", 128'(commit_pulse), 128'(1'b0));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; vblank = 1'b0;
    in_xl = '0; in_xr = '0; in_yu = '0; in_yd = '0; in_py = '0; in_gm = '0;
    model_reset();
    cyc(3);
    chk_reset("rst_init");
    rst_n = 1'b1;
    cyc(3);

    // Basic commit with the patterned snapshot
    for (int i = 0; i < int'(N); i++) begin
      in_xl[i*10 +: 10] = 10'(10 * i);
      in_xr[i*10 +: 10] = 10'(10 * i + 20);
      in_yu[i*9 +: 9]   = 9'(5 * i);
      in_yd[i*9 +: 9]   = 9'(5 * i + 40);
    end
    in_py = 9'd123;
    in_gm = 2'd2;
    req = 1'b1;
    push_exp();
    cyc(2);
    chk("basic_busy_c2", 128'(busy), 128'(1'b0));
    cyc(1);
    chk("basic_busy_c3", 128'(busy), 128'(1'b1));
    cyc(47);
    chk_shadows("basic_prevb");
    do_frame(20, 0, ca);
    chk("basic_commit_at", 128'(ca), 128'(11));
    chk("basic_ack", 128'(upd_ack_tgl), 128'(1'b1));
    chk("basic_busy_end", 128'(busy), 128'(1'b0));
    chk_shadows("basic_post");

    // Request arrives while already blanking
    rand_inputs();
    vblank = 1'b1;
    cyc(2);
    req = ~req;
    push_exp();
    cyc(10);
    chk("midblank_busy", 128'(busy), 128'(1'b1));
    chk_shadows("midblank_hold1");
    cyc(5);
    vblank = 1'b0;
    cyc(5);
    chk_shadows("midblank_hold2");
    do_frame(20, 0, ca);
    chk("midblank_commit_at", 128'(ca), 128'(11));
    chk_shadows("midblank_post");

    // Inputs wiggle with no request pending
    rand_inputs();
    cyc(5);
    do_frame(20, 0, ca);
    chk("antitear_no_commit", 128'(ca), 128'(0));
    chk_shadows("antitear");

    // Two extra toggles while waiting for blanking
    rand_inputs();
    req = ~req;
    push_exp();
    cyc(6);
    req = ~req;
    cyc(6);
    req = ~req;
    cyc(6);
    chk("ovr_cnt2", 128'(overrun_cnt), 128'(8'd2));
    do_frame(20, 0, ca);
    chk("ovr_commit_at", 128'(ca), 128'(11));
    chk("ovr_ack", 128'(upd_ack_tgl), 128'(req));
    do_frame(20, 0, ca);
    chk("ovr_no_second", 128'(ca), 128'(0));
    chk("ovr_busy", 128'(busy), 128'(1'b0));

    // New toggle lands in the DONE cycle
    rand_inputs();
    req = ~req;
    push_exp();
    cyc(6);
    do_frame(20, 9, ca);
    chk("b2b_commit_at", 128'(ca), 128'(11));
    chk("b2b_ovr", 128'(overrun_cnt), 128'(8'd2));
    chk("b2b_busy_wait", 128'(busy), 128'(1'b1));
    rand_inputs();
    push_exp();
    cyc(4);
    do_frame(20, 0, ca);
    chk("b2b_second_at", 128'(ca), 128'(11));
    chk("b2b_ack", 128'(upd_ack_tgl), 128'(req));
    chk_shadows("b2b_post");

    // Overrun counter saturation
    rand_inputs();
    req = ~req;
    push_exp();
    cyc(6);
    repeat (300) begin
      req = ~req;
      cyc(3);
    end
    cyc(4);
    chk("ovr_sat", 128'(overrun_cnt), 128'(8'd255));
    do_frame(20, 0, ca);
    chk("sat_commit_at", 128'(ca), 128'(11));
    chk("sat_ack", 128'(upd_ack_tgl), 128'(req));
    chk("sat_hold", 128'(overrun_cnt), 128'(8'd255));

    // Randomized traffic
    for (int k = 0; k < 10; k++) begin
      bit do_tgl;
      do_tgl = ($urandom_range(0, 3) != 0);
      rand_inputs();
      if (do_tgl) begin
        req = ~req;
        push_exp();
      end
      cyc($urandom_range(4, 60));
      do_frame($urandom_range(12, 30), 0, ca);
      chk("rand_commit_at", 128'(ca), do_tgl ? 128'(11) : 128'(0));
      chk_shadows("rand");
      chk("rand_ack", 128'(upd_ack_tgl), 128'(req));
    end

    // Reset in the middle of a copy (slot 4)
    rand_inputs();
    req = ~req;
    cyc(6);
    vblank = 1'b1;
    cyc(5);
    chk("midcopy_busy", 128'(busy), 128'(1'b1));
    rst_n = 1'b0;
    req = 1'b0;
    vblank = 1'b0;
    #1;
    chk_reset("rst_midcopy");
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk_shadows("rst_post");

    // Recovery commit after reset
    rand_inputs();
    req = 1'b1;
    push_exp();
    cyc(6);
    do_frame(20, 0, ca);
    chk("recover_commit_at", 128'(ca), 128'(11));
    chk("recover_ack", 128'(upd_ack_tgl), 128'(1'b1));
    chk_shadows("recover");

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
